// File: rtl/imm_chunker.sv
// Splits a 32-bit word into MSB-first 6-bit immediate chunks, skipping leading all-zero chunks.
// Chunk 0 appears the cycle after accept; outputs hold under out_ready=0; new input is taken only when idle.
module imm_chunker #(
  parameter int WORD_W = 32,
  parameter int IMM_W  = 6,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_first,
  output logic              out_last,
  output logic              out_fits
);

  localparam int MAX_CHUNKS = (WORD_W + IMM_W - 1) / IMM_W;
  localparam int PAD_W      = MAX_CHUNKS * IMM_W;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  value_q, value_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               fits_q, fits_d;
  logic [IDX_W-1:0]   top_pos;

  // pos counts chunks from the LSB end; bits above WORD_W read as zero.
  function automatic logic [IMM_W-1:0] chunk_at(input logic [WORD_W-1:0] v,
                                                input logic [IDX_W-1:0]  pos);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(v);
    return pad[int'(pos)*IMM_W +: IMM_W];
  endfunction

  function automatic logic [IDX_W-1:0] top_chunk(input logic [WORD_W-1:0] v);
    logic [IDX_W-1:0] top;
    top = '0;
    for (int k = 0; k < MAX_CHUNKS; k++) begin
      if (chunk_at(v, IDX_W'(k)) != '0) top = IDX_W'(k);
    end
    return top;
  endfunction

  always_comb begin
    top_pos = top_chunk(in_value);
    state_d = state_q;
    value_d = value_q;
    pos_d   = pos_q;
    imm_d   = imm_q;
    idx_d   = idx_q;
    first_d = first_q;
    last_d  = last_q;
    fits_d  = fits_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          value_d = in_value;
          pos_d   = top_pos;
          imm_d   = chunk_at(in_value, top_pos);
          idx_d   = '0;
          first_d = 1'b1;
          last_d  = (top_pos == '0);
          fits_d  = (top_pos == '0);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            // Return outputs to zero so nothing stale is visible while idle.
            state_d = IDLE;
            value_d = '0;
            pos_d   = '0;
            imm_d   = '0;
            idx_d   = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
            fits_d  = 1'b0;
          end else begin
            pos_d   = pos_q - 1'b1;
            imm_d   = chunk_at(value_q, pos_q - 1'b1);
            idx_d   = idx_q + 1'b1;
            first_d = 1'b0;
            last_d  = (pos_q == IDX_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= '0;
      pos_q   <= '0;
      imm_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      fits_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pos_q   <= pos_d;
      imm_q   <= imm_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      fits_q  <= fits_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_imm   = imm_q;
  assign out_index = idx_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_fits  = fits_q;

endmodule

// File: tb/tb_imm_chunker.sv
// Directed and randomised checks of imm_chunker chunking, handshake timing, backpressure and reset.
module tb_imm_chunker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_imm;
  logic [2:0]  out_index;
  logic        out_first;
  logic        out_last;
  logic        out_fits;

  int total = 0;
  int bad   = 0;

  logic [5:0] got_imm[8];
  logic [2:0] got_idx[8];
  logic       got_first[8];
  logic       got_last[8];
  logic       got_fits[8];
  int         got_n;
  logic       got_lat;

  imm_chunker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_index(out_index), .out_first(out_first), .out_last(out_last),
    .out_fits(out_fits)
  );

  always #5 clk = ~clk;

  function automatic int exp_n(input logic [31:0] v);
    int bitlen;
    bitlen = 0;
    for (int i = 0; i < 32; i++) if (v[i]) bitlen = i + 1;
    return (bitlen == 0) ? 1 : (bitlen + 5) / 6;
  endfunction

  function automatic logic [63:0] reasm(input int n);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < n && i < 8; i++) acc = (acc << 6) | 64'(got_imm[i]);
    return acc;
  endfunction

  // Returns at the negedge after the accepting posedge, with in_valid dropped.
  task automatic offer(input logic [31:0] v);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = $urandom;
  endtask

  task automatic run_stream(input logic [31:0] v, input bit rnd);
    bit done;
    offer(v);
    got_lat = out_valid && (out_index == 3'd0);
    got_n = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (got_n < 8) begin
          got_imm[got_n]   = out_imm;
          got_idx[got_n]   = out_index;
          got_first[got_n] = out_first;
          got_last[got_n]  = out_last;
          got_fits[got_n]  = out_fits;
        end
        got_n++;
        if (out_last) done = 1'b1;
      end
      @(posedge clk);
    end
    if (!done) got_n = 99;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
    #3;
    total++;
    if ({out_valid, out_imm, out_index, out_first, out_last, out_fits} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b imm=%h idx=%0d f=%b l=%b fits=%b want all 0",
               out_valid, out_imm, out_index, out_first, out_last, out_fits);
    end
    #10;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    run_stream(32'h0000002A, 1'b0);
    total++;
    if (got_n !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_n); end
    total++;
    if (got_lat !== 1'b1) begin bad++; $display("FAIL single_latency: got valid-at-t+1=%b want 1", got_lat); end
    total++;
    if (got_imm[0] !== 6'h2A) begin bad++; $display("FAIL single_imm: got %h want 2a", got_imm[0]); end
    total++;
    if ({got_first[0], got_last[0], got_fits[0]} !== 3'b111) begin
      bad++;
      $display("FAIL single_flags: got first/last/fits=%b%b%b want 111", got_first[0], got_last[0], got_fits[0]);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_imm !== 6'h00) begin
      bad++;
      $display("FAIL single_idle_after: got in_ready=%b out_valid=%b imm=%h want 1/0/00", in_ready, out_valid, out_imm);
    end
  endtask

  task automatic test_two();
    run_stream(32'h00000040, 1'b0);
    total++;
    if (got_n !== 2) begin bad++; $display("FAIL two_count: got %0d want 2", got_n); end
    total++;
    if (got_imm[0] !== 6'h01 || got_imm[1] !== 6'h00) begin
      bad++;
      $display("FAIL two_imm: got %h,%h want 01,00", got_imm[0], got_imm[1]);
    end
    total++;
    if (got_idx[0] !== 3'd0 || got_idx[1] !== 3'd1) begin
      bad++;
      $display("FAIL two_index: got %0d,%0d want 0,1", got_idx[0], got_idx[1]);
    end
    total++;
    if ({got_first[0], got_last[0], got_first[1], got_last[1]} !== 4'b1001) begin
      bad++;
      $display("FAIL two_first_last: got %b%b%b%b want 1001", got_first[0], got_last[0], got_first[1], got_last[1]);
    end
    total++;
    if (got_fits[0] !== 1'b0 || got_fits[1] !== 1'b0) begin
      bad++;
      $display("FAIL two_fits: got %b,%b want 0,0", got_fits[0], got_fits[1]);
    end
  endtask

  task automatic test_full_and_zero();
    logic [5:0] exp_full[6];
    exp_full = '{6'h03, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    run_stream(32'hFFFFFFFF, 1'b0);
    total++;
    if (got_n !== 6) begin bad++; $display("FAIL full_count: got %0d want 6", got_n); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got_imm[k] !== exp_full[k] || got_idx[k] !== 3'(k)) begin
        bad++;
        $display("FAIL full_chunk%0d: got imm=%h idx=%0d want imm=%h idx=%0d", k, got_imm[k], got_idx[k], exp_full[k], k);
      end
    end
    total++;
    if (reasm(6) !== 64'h00000000FFFFFFFF) begin
      bad++;
      $display("FAIL full_reassembly: got %h want ffffffff", reasm(6));
    end
    run_stream(32'h00000000, 1'b0);
    total++;
    if (got_n !== 1 || got_imm[0] !== 6'h00 || got_fits[0] !== 1'b1 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL zero_stream: got n=%0d imm=%h fits=%b last=%b want 1/00/1/1", got_n, got_imm[0], got_fits[0], got_last[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_bp[5];
    exp_bp = '{6'h12, 6'h0D, 6'h05, 6'h19, 6'h38};
    out_ready = 1'b1;
    offer(32'h12345678);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          out_ready = 1'b0;
          in_valid  = 1'b1;
          in_value  = 32'hFFFFFFFF;
          total++;
          if (out_valid !== 1'b1 || out_imm !== 6'h05 || out_index !== 3'd2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got valid=%b imm=%h idx=%0d in_ready=%b want 1/05/2/0",
                     s, out_valid, out_imm, out_index, in_ready);
          end
          @(posedge clk);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      total++;
      if (out_valid !== 1'b1 || out_imm !== exp_bp[k] || out_index !== 3'(k) || out_last !== (k == 4)) begin
        bad++;
        $display("FAIL bp_chunk%0d: got valid=%b imm=%h idx=%0d last=%b want 1/%h/%0d/%b",
                 k, out_valid, out_imm, out_index, out_last, exp_bp[k], k, (k == 4));
      end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_end: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    offer(32'hFFFFFFFF);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (out_index !== 3'd3 || out_imm !== 6'h3F) begin
      bad++;
      $display("FAIL rstmid_pre: got idx=%0d imm=%h want 3/3f", out_index, out_imm);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_imm !== 6'h00 || out_index !== 3'd0) begin
      bad++;
      $display("FAIL rstmid_async: got valid=%b imm=%h idx=%0d want 0/00/0", out_valid, out_imm, out_index);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    run_stream(32'h00000005, 1'b0);
    total++;
    if (got_n !== 1 || got_imm[0] !== 6'h05 || got_fits[0] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_next: got n=%0d imm=%h fits=%b want 1/05/1", got_n, got_imm[0], got_fits[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 1500; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      run_stream(v, 1'b1);
      total++;
      if (got_n !== exp_n(v)) begin
        bad++;
        $display("FAIL rand_count: value=%h got %0d want %0d", v, got_n, exp_n(v));
      end
      total++;
      if (reasm(got_n) !== {32'h0, v}) begin
        bad++;
        $display("FAIL rand_reassembly: value=%h got %h", v, reasm(got_n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_full_and_zero();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
